// File: rtl/line_buffer_ctrl_if.sv
// Handshake and window-tag bundle between the line-buffer controller,
// the pixel source, the line-buffer chain and the window consumer.
interface line_buffer_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             busy;
   logic             done;
   logic             in_vld;
   logic             in_rdy;
   logic             out_rdy;
   logic             sr_shift;
   logic             sr_rst_n;
   logic             win_vld;
   logic [CNT_W-1:0] win_row;
   logic [CNT_W-1:0] win_col;

   // Controller side
   modport master (
      input  start, in_vld, out_rdy,
      output busy, done, in_rdy, sr_shift, sr_rst_n, win_vld, win_row, win_col
   );

   // Environment side (pixel source, line buffers, window consumer)
   modport slave (
      output start, in_vld, out_rdy,
      input  busy, done, in_rdy, sr_shift, sr_rst_n, win_vld, win_row, win_col
   );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: walks one raster frame per start command, shifts the
// line buffers on every accepted pixel and tags each complete KxK window with
// its output-map coordinates, one cycle after the pixel that completes it.
module line_buffer_ctrl #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 3,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   line_buffer_ctrl_if.master lb
);

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] KM1      = CNT_W'(K - 1);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic             winVld_q, winVld_d;
   logic [CNT_W-1:0] winRow_q, winRow_d;
   logic [CNT_W-1:0] winCol_q, winCol_d;

   logic inRdy;
   logic accept;
   logic lastPixel;

   // out_rdy is a look-ahead: taking a pixel now guarantees the consumer can
   // absorb the window that appears on the next cycle
   assign inRdy     = (state_q == RUN) & lb.out_rdy;
   assign accept    = inRdy & lb.in_vld;
   assign lastPixel = (row_q == LAST_ROW) & (col_q == LAST_COL);

   // Next-state and raster position tracking
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (lb.start) state_d = CLR;
         end
         CLR: begin
            row_d   = '0;
            col_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (accept) begin
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (lastPixel) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A window is complete once K-1 rows and K-1 columns have been buffered;
   // its tag is held between windows so the consumer sees stable coordinates
   always_comb begin
      winVld_d = accept & (row_q >= KM1) & (col_q >= KM1);
      winRow_d = winRow_q;
      winCol_d = winCol_q;
      if (winVld_d) begin
         winRow_d = row_q - KM1;
         winCol_d = col_q - KM1;
      end
   end

   // State, position and window-tag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         winVld_q <= 1'b0;
         winRow_q <= '0;
         winCol_q <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         winVld_q <= winVld_d;
         winRow_q <= winRow_d;
         winCol_q <= winCol_d;
      end
   end

   assign lb.busy     = (state_q != IDLE);
   assign lb.done     = (state_q == DONE);
   assign lb.in_rdy   = inRdy;
   assign lb.sr_shift = accept;
   assign lb.sr_rst_n = rst & (state_q != CLR);
   assign lb.win_vld  = winVld_q;
   assign lb.win_row  = winRow_q;
   assign lb.win_col  = winCol_q;

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences the pixel line-buffer chain (variable-depth shift registers) that feeds the KxK convolution window.
- Accepts one raster-order frame per start command and tracks the row/column position of each pixel.
- Drives the shift-register enable and clear.
- Flags each cycle in which the line-buffer outputs form a complete valid (unpadded) window, tagged with the window's output coordinates.

Parameters:
IMG_W, 28, image width in pixels (>= K)
IMG_H, 28, image height in pixels (>= K)
K, 3, kernel size; window complete when row >= K-1 and col >= K-1
CNT_W, 8, width of row/column counters and coordinate outputs (2^CNT_W > max(IMG_W, IMG_H))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin one frame; sampled only in IDLE
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after last window of frame issued
in_vld  input  1  upstream pixel valid
in_rdy  output  1  controller can accept pixel this cycle
out_rdy  input  1  downstream look-ahead ready: can take a window next cycle
sr_shift  output  1  shift enable to line buffers (drives their input_vld)
sr_rst_n  output  1  active-low synchronous clear to line buffers
win_vld  output  1  line-buffer outputs hold a complete window this cycle
win_row  output  CNT_W  output-map row of window (pixel row - (K-1))
win_col  output  CNT_W  output-map col of window (pixel col - (K-1))

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; row=col=0; busy=done=in_rdy=sr_shift=win_vld=0; win_row=win_col=0; sr_rst_n=0 while rst low.
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE: in_rdy=0. start=1 -> CLR.
- CLR (exactly 1 cycle): sr_rst_n=0, row=col=0, in_rdy=0 -> RUN.
- RUN: in_rdy = out_rdy (combinational). Accept = in_vld & in_rdy. sr_shift = accept (combinational, same cycle).
- Counter advance on accept: col+1; when col=IMG_W-1, col wraps to 0 and row+1.
- Leaving RUN: accept at row=IMG_H-1, col=IMG_W-1 -> DONE. No further pixels accepted this frame.
- DONE (1 cycle): done=1, in_rdy=0 -> IDLE.
- sr_rst_n = rst & (state != CLR) at all times.
- win_vld is registered: win_vld(t+1) = accept(t) & row(t) >= K-1 & col(t) >= K-1.
  - On such an accept, win_row(t+1)=row(t)-(K-1) and win_col(t+1)=col(t)-(K-1).
  - Otherwise win_vld=0 and win_row/win_col hold their last values.
  - 1-cycle latency matches the line buffers' registered dout.
- Final window's win_vld is high during the DONE cycle, the same cycle as done.
- Downstream must consume win_vld unconditionally: out_rdy is a one-cycle look-ahead, and accept requires out_rdy=1 in the previous cycle.
- in_vld with out_rdy=0: no accept, no shift, counters hold, win_vld=0 next cycle.
- start while busy: ignored. start held high through DONE: a new frame begins on the IDLE cycle that follows.
- in_vld outside RUN: ignored (in_rdy=0).
- Window count per frame: (IMG_W-K+1)*(IMG_H-K+1); 676 for defaults.
- Reset mid-frame returns to IDLE immediately. Partial frame discarded; no done pulse.

Test Plan:
1. Reset, then start with in_vld=1 and out_rdy=1 continuously (defaults) -> exactly 784 sr_shift cycles and 676 win_vld pulses.
   - First win_vld has win_row=0, win_col=0, one cycle after the pixel at (2,2) (accept #59).
   - Last win_vld has (25,25), coincident with done.
   - busy high from start+1 through the DONE cycle.
2. Start -> CLR cycle shows sr_rst_n=0 and in_rdy=0 for exactly one cycle; first accept no earlier than 2 cycles after start.
3. Toggle out_rdy 1,0,0,1 mid-row at col=10 -> in_rdy follows out_rdy, no sr_shift while low, counter holds at col 10, and the window sequence has no gaps or duplicates.
4. Random in_vld gaps (50% duty) with out_rdy=1 -> still 676 windows, coordinates strictly raster-ordered, win_vld only one cycle after an accept.
5. Assert rst low at pixel 300 -> all outputs zero asynchronously, state IDLE, no done. The next start completes a full frame with 676 windows.
6. Pulse start during RUN and hold start high through DONE -> mid-frame start ignored, second frame starts on the IDLE cycle after DONE, both frames 676 windows.
